// File: rtl/posit_pkg.sv
// Shared posit definitions for the decoder, the multiplier and the quire.
// Holds the width helpers that the dependent widths come from, and the
// decoded-posit record type used for the default 8/2 configuration.
package posit_pkg;

    // Scale width: enough for the regime run-length (up to N-1) times 2^ES,
    // plus the exponent bits and a sign bit.
    function automatic int posit_scale_w(input int posit_width, input int posit_es);
        return $clog2(posit_width - 1) + posit_es + 1;
    endfunction

    // The exact product of two hidden-bit significands needs twice their width.
    function automatic int posit_pfrac_w(input int frac_w);
        return 2 * (frac_w + 1);
    endfunction

    // One extra bit so that the sum of two scales cannot overflow.
    function automatic int posit_pscale_w(input int scale_w);
        return scale_w + 1;
    endfunction

    localparam int DEF_POSIT_WIDTH = 8;
    localparam int DEF_POSIT_ES    = 2;
    localparam int DEF_FRAC_W      = 12;
    localparam int DEF_SCALE_W     = posit_scale_w(DEF_POSIT_WIDTH, DEF_POSIT_ES);

    typedef struct packed {
        logic                   sign;
        logic                   zero;
        logic                   NaR;
        logic [DEF_SCALE_W-1:0] scale;
        logic [DEF_FRAC_W-1:0]  fraction;
    } posit_dec_t;

endpackage

// File: rtl/posit_mult_core.sv
// Combinational core of the posit multiplier.
// Ports:
//   fraction_1/2 : fraction bits following the implicit leading 1
//   scale_1/2    : two's-complement scales
//   nar_1/2, zero_1/2, sign_1/2 : operand flags
//   fraction     : exact significand product (2 integer bits)
//   scale        : summed scale, one bit wider than the inputs
//   nar, zero, sign : product flags
// Zero and NaR products force fraction, scale and sign to 0.
module posit_mult_core
    import posit_pkg::*;
#(
    parameter  int FRAC_W   = 12,
    parameter  int SCALE_W  = 6,
    localparam int PFRAC_W  = posit_pfrac_w(FRAC_W),
    localparam int PSCALE_W = posit_pscale_w(SCALE_W)
) (
    input  logic [FRAC_W-1:0]   fraction_1,
    input  logic [FRAC_W-1:0]   fraction_2,
    input  logic [SCALE_W-1:0]  scale_1,
    input  logic [SCALE_W-1:0]  scale_2,
    input  logic                nar_1,
    input  logic                nar_2,
    input  logic                zero_1,
    input  logic                zero_2,
    input  logic                sign_1,
    input  logic                sign_2,
    output logic [PFRAC_W-1:0]  fraction,
    output logic [PSCALE_W-1:0] scale,
    output logic                nar,
    output logic                zero,
    output logic                sign
);

    logic [PFRAC_W-1:0]  sig_1;
    logic [PFRAC_W-1:0]  sig_2;
    logic [PFRAC_W-1:0]  product;
    logic [PSCALE_W-1:0] scale_sum;
    logic                special;

    // Both significands are widened to the product width first so that the
    // multiply is carried out at full width and never truncates.
    assign sig_1     = {{(PFRAC_W-FRAC_W-1){1'b0}}, 1'b1, fraction_1};
    assign sig_2     = {{(PFRAC_W-FRAC_W-1){1'b0}}, 1'b1, fraction_2};
    assign product   = sig_1 * sig_2;
    assign scale_sum = {scale_1[SCALE_W-1], scale_1} + {scale_2[SCALE_W-1], scale_2};

    // NaR dominates zero: NaR times zero is NaR.
    assign nar     = nar_1 | nar_2;
    assign zero    = (zero_1 | zero_2) & ~nar;
    assign special = nar | zero;

    assign fraction = special ? '0   : product;
    assign scale    = special ? '0   : scale_sum;
    assign sign     = special ? 1'b0 : (sign_1 ^ sign_2);

endmodule

// File: rtl/posit_mult_stage.sv
// Pipelined multiplier stage for two decoded posits, feeding the quire.
// A single output register with an rts/rtr handshake; one cycle of latency
// and full throughput.
// Ports:
//   clk, rst                : clock and asynchronous active-high reset
//   rts_i / rtr_o           : upstream valid / ready
//   sow_i, eow_i            : window markers, qualified by rts_i
//   fraction_i*, scale_i*, NaR_i*, zero_i*, sign_i* : decoded operands
//   rtr_i / rts_o           : downstream ready / valid
//   sow_o, eow_o            : window markers travelling with the product
//   fraction_o, scale_o, NaR_o, zero_o, sign_o : unnormalised product
module posit_mult_stage
    import posit_pkg::*;
#(
    parameter  int POSIT_WIDTH = 8,
    parameter  int POSIT_ES    = 2,
    parameter  int FRAC_W      = 12,
    localparam int SCALE_W     = posit_scale_w(POSIT_WIDTH, POSIT_ES),
    localparam int PFRAC_W     = posit_pfrac_w(FRAC_W),
    localparam int PSCALE_W    = posit_pscale_w(SCALE_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rts_i,
    output logic                rtr_o,
    input  logic                sow_i,
    input  logic                eow_i,
    input  logic [FRAC_W-1:0]   fraction_i1,
    input  logic [FRAC_W-1:0]   fraction_i2,
    input  logic [SCALE_W-1:0]  scale_i1,
    input  logic [SCALE_W-1:0]  scale_i2,
    input  logic                NaR_i1,
    input  logic                NaR_i2,
    input  logic                zero_i1,
    input  logic                zero_i2,
    input  logic                sign_i1,
    input  logic                sign_i2,
    input  logic                rtr_i,
    output logic                rts_o,
    output logic                sow_o,
    output logic                eow_o,
    output logic [PFRAC_W-1:0]  fraction_o,
    output logic [PSCALE_W-1:0] scale_o,
    output logic                NaR_o,
    output logic                zero_o,
    output logic                sign_o
);

    logic [PFRAC_W-1:0]  core_fraction;
    logic [PSCALE_W-1:0] core_scale;
    logic                core_nar;
    logic                core_zero;
    logic                core_sign;
    logic                accept;

    posit_mult_core #(
        .FRAC_W  (FRAC_W),
        .SCALE_W (SCALE_W)
    ) u_core (
        .fraction_1 (fraction_i1),
        .fraction_2 (fraction_i2),
        .scale_1    (scale_i1),
        .scale_2    (scale_i2),
        .nar_1      (NaR_i1),
        .nar_2      (NaR_i2),
        .zero_1     (zero_i1),
        .zero_2     (zero_i2),
        .sign_1     (sign_i1),
        .sign_2     (sign_i2),
        .fraction   (core_fraction),
        .scale      (core_scale),
        .nar        (core_nar),
        .zero       (core_zero),
        .sign       (core_sign)
    );

    // The register can take a new word whenever it is empty or is being
    // drained this cycle, which gives back-to-back transfers without a bubble.
    assign rtr_o  = rtr_i | ~rts_o;
    assign accept = rts_i & rtr_o;

    // Handshake register. An accepted word always loads; otherwise the valid
    // flag drops only when the held word leaves. Data is left untouched
    // when the register empties, so only rts_o needs to be cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rts_o      <= 1'b0;
            sow_o      <= 1'b0;
            eow_o      <= 1'b0;
            fraction_o <= '0;
            scale_o    <= '0;
            NaR_o      <= 1'b0;
            zero_o     <= 1'b0;
            sign_o     <= 1'b0;
        end else if (accept) begin
            rts_o      <= 1'b1;
            sow_o      <= sow_i;
            eow_o      <= eow_i;
            fraction_o <= core_fraction;
            scale_o    <= core_scale;
            NaR_o      <= core_nar;
            zero_o     <= core_zero;
            sign_o     <= core_sign;
        end else if (rtr_i) begin
            rts_o      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_posit_mult_stage.sv
// Scoreboard bench for posit_mult_stage. Directed vectors carry their
// hand-computed products; the stimulus side queues the expected result when
// a word is accepted and a monitor pops and compares on every output transfer.
module tb_posit_mult_stage;

    typedef struct packed {
        logic [11:0] f1;
        logic [5:0]  s1;
        logic        n1;
        logic        z1;
        logic        g1;
        logic [11:0] f2;
        logic [5:0]  s2;
        logic        n2;
        logic        z2;
        logic        g2;
        logic        sow;
        logic        eow;
        logic [25:0] ef;
        logic [6:0]  es;
        logic        en;
        logic        ez;
        logic        eg;
    } vec_t;

    logic        tb_clk;
    logic        tb_reset_n;
    logic        rts_i;
    logic        rtr_o;
    logic        sow_i;
    logic        eow_i;
    logic [11:0] fraction_i1;
    logic [11:0] fraction_i2;
    logic [5:0]  scale_i1;
    logic [5:0]  scale_i2;
    logic        NaR_i1;
    logic        NaR_i2;
    logic        zero_i1;
    logic        zero_i2;
    logic        sign_i1;
    logic        sign_i2;
    logic        rtr_i;
    logic        rts_o;
    logic        sow_o;
    logic        eow_o;
    logic [25:0] fraction_o;
    logic [6:0]  scale_o;
    logic        NaR_o;
    logic        zero_o;
    logic        sign_o;

    int   tests_run;
    int   tests_failed;
    bit   check_tput;
    vec_t vecs [0:12];
    vec_t exp_q [$];

    posit_mult_stage dut (
        .clk         (tb_clk),
        .rst         (~tb_reset_n),
        .rts_i       (rts_i),
        .rtr_o       (rtr_o),
        .sow_i       (sow_i),
        .eow_i       (eow_i),
        .fraction_i1 (fraction_i1),
        .fraction_i2 (fraction_i2),
        .scale_i1    (scale_i1),
        .scale_i2    (scale_i2),
        .NaR_i1      (NaR_i1),
        .NaR_i2      (NaR_i2),
        .zero_i1     (zero_i1),
        .zero_i2     (zero_i2),
        .sign_i1     (sign_i1),
        .sign_i2     (sign_i2),
        .rtr_i       (rtr_i),
        .rts_o       (rts_o),
        .sow_o       (sow_o),
        .eow_o       (eow_o),
        .fraction_o  (fraction_o),
        .scale_o     (scale_o),
        .NaR_o       (NaR_o),
        .zero_o      (zero_o),
        .sign_o      (sign_o)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drives one word and holds it until accepted; the expected product is
    // queued on the cycle the handshake completes.
    task automatic applyStimulus(input vec_t v);
        int tries = 0;
        bit done  = 0;
        fraction_i1 = v.f1;  scale_i1 = v.s1;
        NaR_i1 = v.n1;  zero_i1 = v.z1;  sign_i1 = v.g1;
        fraction_i2 = v.f2;  scale_i2 = v.s2;
        NaR_i2 = v.n2;  zero_i2 = v.z2;  sign_i2 = v.g2;
        sow_i = v.sow;  eow_i = v.eow;
        rts_i = 1'b1;
        while (!done) begin
            @(negedge tb_clk);
            if (check_tput) begin
                checkOutput("tput_rts_o", 32'(rts_o), 32'd1);
                checkOutput("tput_rtr_o", 32'(rtr_o), 32'd1);
            end
            if (rtr_o) begin
                exp_q.push_back(v);
                done = 1;
            end else if (++tries >= 20) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL accept_timeout: rtr_o stuck at %0b, expected 1", rtr_o);
                done = 1;
            end
            @(posedge tb_clk);
            #1;
        end
    endtask

    // Monitor: every output transfer must match the oldest queued product.
    always @(negedge tb_clk) begin
        if (tb_reset_n && rts_o && rtr_i) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_output: got fraction 0x%0h, expected no output", fraction_o);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                checkOutput("fraction_o", 32'(fraction_o), 32'(e.ef));
                checkOutput("scale_o",    32'(scale_o),    32'(e.es));
                checkOutput("flags_nzs",  32'({NaR_o, zero_o, sign_o}), 32'({e.en, e.ez, e.eg}));
                checkOutput("sow_eow",    32'({sow_o, eow_o}), 32'({e.sow, e.eow}));
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        check_tput   = 0;

        //                f1      s1     n z g   f2      s2     n z g   sow eow  product      scale  n z g
        vecs[0]  = '{12'h000, 6'h03, 1'b0,1'b0,1'b0, 12'h800, 6'h3E, 1'b0,1'b0,1'b1, 1'b0,1'b0, 26'h1800000, 7'h01, 1'b0,1'b0,1'b1};
        vecs[1]  = '{12'hFFF, 6'h18, 1'b0,1'b0,1'b0, 12'hFFF, 6'h18, 1'b0,1'b0,1'b0, 1'b0,1'b0, 26'h3FFC001, 7'h30, 1'b0,1'b0,1'b0};
        vecs[2]  = '{12'hFFF, 6'h28, 1'b0,1'b0,1'b1, 12'hFFF, 6'h28, 1'b0,1'b0,1'b1, 1'b0,1'b0, 26'h3FFC001, 7'h50, 1'b0,1'b0,1'b0};
        vecs[3]  = '{12'hABC, 6'h05, 1'b0,1'b1,1'b0, 12'h800, 6'h02, 1'b0,1'b0,1'b0, 1'b0,1'b0, 26'h0000000, 7'h00, 1'b0,1'b1,1'b0};
        vecs[4]  = '{12'h123, 6'h07, 1'b0,1'b1,1'b1, 12'h456, 6'h01, 1'b1,1'b0,1'b1, 1'b0,1'b0, 26'h0000000, 7'h00, 1'b1,1'b0,1'b0};
        vecs[5]  = '{12'h800, 6'h1F, 1'b0,1'b0,1'b1, 12'h800, 6'h1F, 1'b0,1'b0,1'b0, 1'b0,1'b0, 26'h2400000, 7'h3E, 1'b0,1'b0,1'b1};
        vecs[6]  = '{12'h001, 6'h20, 1'b0,1'b0,1'b0, 12'h001, 6'h20, 1'b0,1'b0,1'b0, 1'b0,1'b0, 26'h1002001, 7'h40, 1'b0,1'b0,1'b0};
        vecs[7]  = '{12'h400, 6'h20, 1'b0,1'b0,1'b0, 12'hC00, 6'h1F, 1'b0,1'b0,1'b1, 1'b0,1'b0, 26'h2300000, 7'h7F, 1'b0,1'b0,1'b1};
        vecs[8]  = '{12'hFFF, 6'h18, 1'b1,1'b0,1'b1, 12'h000, 6'h00, 1'b0,1'b0,1'b0, 1'b0,1'b0, 26'h0000000, 7'h00, 1'b1,1'b0,1'b0};
        vecs[9]  = '{12'h000, 6'h00, 1'b0,1'b0,1'b0, 12'h000, 6'h00, 1'b0,1'b0,1'b0, 1'b1,1'b0, 26'h1000000, 7'h00, 1'b0,1'b0,1'b0};
        vecs[10] = '{12'h800, 6'h01, 1'b0,1'b0,1'b0, 12'h800, 6'h02, 1'b0,1'b0,1'b0, 1'b0,1'b0, 26'h2400000, 7'h03, 1'b0,1'b0,1'b0};
        vecs[11] = '{12'h400, 6'h3F, 1'b0,1'b0,1'b1, 12'hC00, 6'h3F, 1'b0,1'b0,1'b0, 1'b0,1'b0, 26'h2300000, 7'h7E, 1'b0,1'b0,1'b1};
        vecs[12] = '{12'h001, 6'h05, 1'b0,1'b0,1'b0, 12'h001, 6'h3D, 1'b0,1'b0,1'b0, 1'b0,1'b1, 26'h1002001, 7'h02, 1'b0,1'b0,1'b0};

        tb_reset_n = 1'b0;
        rts_i = 1'b0;  rtr_i = 1'b1;  sow_i = 1'b0;  eow_i = 1'b0;
        fraction_i1 = '0;  fraction_i2 = '0;  scale_i1 = '0;  scale_i2 = '0;
        NaR_i1 = 1'b0;  NaR_i2 = 1'b0;  zero_i1 = 1'b0;  zero_i2 = 1'b0;
        sign_i1 = 1'b0;  sign_i2 = 1'b0;

        // Reset state
        #2;
        checkOutput("reset_ctrl", 32'({rts_o, sow_o, eow_o, NaR_o, zero_o, sign_o}), 32'd0);
        checkOutput("reset_data", 32'({fraction_o, scale_o[5:0]}) ^ 32'(scale_o[6]), 32'd0);
        repeat (2) @(posedge tb_clk);
        #1 tb_reset_n = 1'b1;
        #1 checkOutput("rtr_after_reset", 32'(rtr_o), 32'd1);
        @(posedge tb_clk);
        #1;

        // Directed products streamed back to back: also the throughput check
        for (int i = 0; i <= 8; i++) begin
            applyStimulus(vecs[i]);
            check_tput = 1;
        end
        check_tput = 0;
        rts_i = 1'b0;
        repeat (2) @(posedge tb_clk);
        #1;

        // Windowed stream with a three-cycle stall after the second word
        applyStimulus(vecs[9]);
        applyStimulus(vecs[10]);
        fork
            begin
                applyStimulus(vecs[11]);
                applyStimulus(vecs[12]);
                rts_i = 1'b0;
            end
            begin
                rtr_i = 1'b0;
                repeat (3) begin
                    @(negedge tb_clk);
                    checkOutput("stall_rtr_o", 32'(rtr_o), 32'd0);
                    checkOutput("stall_rts_o", 32'(rts_o), 32'd1);
                    checkOutput("stall_fraction", 32'(fraction_o), 32'(vecs[10].ef));
                    checkOutput("stall_scale", 32'(scale_o), 32'(vecs[10].es));
                    @(posedge tb_clk);
                    #1;
                end
                rtr_i = 1'b1;
            end
        join
        repeat (3) @(posedge tb_clk);
        #1;

        // Asynchronous reset while a word is stalled in the register
        rtr_i = 1'b0;
        applyStimulus(vecs[1]);
        rts_i = 1'b0;
        #1 checkOutput("prereset_rts_o", 32'(rts_o), 32'd1);
        tb_reset_n = 1'b0;
        #1;
        checkOutput("async_reset_ctrl", 32'({rts_o, sow_o, eow_o, NaR_o, zero_o, sign_o}), 32'd0);
        checkOutput("async_reset_fraction", 32'(fraction_o), 32'd0);
        checkOutput("async_reset_scale", 32'(scale_o), 32'd0);
        checkOutput("async_reset_rtr_o", 32'(rtr_o), 32'd1);
        exp_q.delete();
        @(posedge tb_clk);
        #1 tb_reset_n = 1'b1;
        rtr_i = 1'b1;
        #1 checkOutput("rtr_after_release", 32'(rtr_o), 32'd1);

        // One more product after reset, then drain the scoreboard
        applyStimulus(vecs[0]);
        rts_i = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge tb_clk);
        #1;
        checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge tb_clk);
        #1;
        checkOutput("idle_rts_o", 32'(rts_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/posit_mult_stage.md
Name: posit_mult_stage

Overview:
- Pipelined multiplier for two decoded (denormalised) posits.
- Multiplies the hidden-bit significands exactly, adds the scales and resolves sign, zero and NaR.
- Emits an unnormalised product to the downstream quire accumulator.
- Sits between the decoded-posit input stream and the quire, with rts/rtr handshake plus start/end-of-window markers.

Parameters:
- POSIT_WIDTH, 8, posit word size N.
- POSIT_ES, 2, exponent field size.
- FRAC_W, 12, input fraction field width, excluding the hidden bit.
- SCALE_W, derived localparam = $clog2(POSIT_WIDTH-1)+POSIT_ES+1 (6 for 8/2). Input scale width, two's complement.
- PFRAC_W, derived = 2*(FRAC_W+1) (26). Product significand width.
- PSCALE_W, derived = SCALE_W+1 (7). Product scale width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rts_i  in  1  input word valid
- rtr_o  out  1  ready to accept input
- sow_i  in  1  start of window, qualified by rts_i
- eow_i  in  1  end of window, qualified by rts_i
- fraction_i1, fraction_i2  in  FRAC_W  fraction bits after the implicit 1
- scale_i1, scale_i2  in  SCALE_W  signed scale (regime*2^ES + exponent)
- NaR_i1, NaR_i2  in  1  operand is NaR
- zero_i1, zero_i2  in  1  operand is zero
- sign_i1, sign_i2  in  1  operand sign
- rtr_i  in  1  downstream ready
- rts_o  out  1  output valid
- sow_o, eow_o  out  1  window markers aligned with output
- fraction_o  out  PFRAC_W  product significand: 2 integer bits, PFRAC_W-2 fraction bits
- scale_o  out  PSCALE_W  signed product scale
- NaR_o, zero_o, sign_o  out  1  product flags

Behaviour:
- Single output register stage; latency 1 cycle from accepted input to rts_o.
- Transfer in: rts_i & rtr_o. Transfer out: rts_o & rtr_i.
- rtr_o = rtr_i | ~rts_o (combinational).
- Accept → load all output registers and set rts_o=1.
- rts_o clears only on an output transfer with no new input accepted in the same cycle.
- Stall (rts_o=1, rtr_i=0): all outputs held stable; rtr_o=0.
- Simultaneous out-transfer and in-accept: register reloads; rts_o stays 1 with no bubble.
- Arithmetic:
  - sig_k = {1'b1, fraction_ik}
  - fraction_o = sig_1 * sig_2, unsigned and exact
  - scale_o = sext(scale_i1) + sext(scale_i2)
  - sign_o = sign_i1 ^ sign_i2
- No normalisation and no rounding: bit PFRAC_W-1 set means the product is ≥ 2. The quire handles alignment.
- Special cases:
  - NaR_o = NaR_i1 | NaR_i2.
  - zero_o = (zero_i1 | zero_i2) & ~NaR_o.
  - If NaR_o or zero_o: fraction_o=0, scale_o=0, sign_o=0.
- Operand fields are don't-care when the matching zero/NaR flag is set.
- sow_o/eow_o are registered copies of sow_i/eow_i, loaded with the data.
- Reset (asynchronous, any time, including mid-stall): all outputs 0 (rts_o, sow_o, eow_o, flags, fraction_o, scale_o); pending word discarded.
- After reset release, rtr_o=1 immediately.

Decomposition:
- Package posit_pkg holds width functions for SCALE_W/PFRAC_W/PSCALE_W and a packed struct posit_dec_t {sign, zero, NaR, scale, fraction}; shared with the decoder and the quire.
- One sub-module, posit_mult_core: combinational significand multiply, scale add and flag logic.
- The top holds only the handshake register.

Test Plan:
- 1.0×1.5: scale 3/frac 0x000 × scale −2 (6'h3E)/frac 0x800, signs 0/1, rtr_i=1 → next cycle rts_o=1, fraction_o=26'h1800000, scale_o=7'h01, sign_o=1, zero_o=0, NaR_o=0.
- Max case: frac 0xFFF both, scale 24 (6'h18) both → fraction_o=26'h3FFC001, scale_o=7'h30. Scales −24 both → scale_o=7'h50 (−48).
- Specials: zero_i1=1 × finite → zero_o=1, fraction_o=0, scale_o=0. NaR_i2=1 with zero_i1=1 → NaR_o=1, zero_o=0.
- Backpressure: stream of 4 words with sow on the first and eow on the last; hold rtr_i=0 for 3 cycles mid-stream → rtr_o=0 and outputs stable while stalled; all 4 products appear in order, none lost or duplicated, sow_o/eow_o on first/last.
- Throughput: continuous rts_i=1, rtr_i=1 → one product per cycle; rts_o never drops after first output.
- Reset mid-stall: assert rst while rts_o=1, rtr_i=0 → all outputs 0 asynchronously (before next clock edge); rtr_o=1 after release.
